mem_access_ctrl: RTL
====================

# mem_access_ctrl

Sequencing controller and two-port arbiter for the 16 x 8 program/data memory of the 8-bit microprocessor. It shares the single memory port between the instruction-fetch requester and the data requester (LDA reads, STA writes). It drives the memory address, active-low output enable and write strobe, and returns captured read data to the winner with a one-cycle acknowledge.

## Interface
Parameters:
- WAIT_CYCLES, 1 — cycles `mem_low_o_en` is held low before read data is captured; legal range 1..4.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- f_req  in  1  fetch request; held until `f_ack`
- f_addr  in  4  fetch address; stable while `f_req` is high
- f_ack  out  1  one-cycle pulse; `f_rdata` valid in the same cycle
- f_rdata  out  8  last fetched byte; held until the next fetch completes
- d_req  in  1  data request; held until `d_ack`
- d_we  in  1  1 = store, 0 = load; stable while `d_req` is high
- d_addr  in  4  data address
- d_wdata  in  8  store data
- d_ack  out  1  one-cycle completion pulse
- d_rdata  out  8  last loaded byte; held until the next load completes
- mem_addr  out  4  memory address
- mem_low_o_en  out  1  memory output enable, active low
- mem_we  out  1  memory write strobe, active high
- mem_wdata  out  8  memory write data
- mem_rdata  in  8  memory read data
- busy  out  1  high in every state except IDLE
- grant_id  out  1  current or last owner: 0 = fetch, 1 = data

## Operation
FSM states are IDLE, SETUP, ACCESS and DONE.

- **IDLE**
  - No request pending: stay in IDLE.
  - Otherwise: arbitrate, latch the winner's address, write enable and write data, go to SETUP.
  - Arbitration is fixed priority, data over fetch.
- **SETUP**
  - `mem_addr` is driven with the latched address.
  - `mem_low_o_en` = 1 and `mem_we` = 0.
  - Always go to ACCESS next.
- **ACCESS, read**
  - `mem_low_o_en` = 0 for exactly WAIT_CYCLES cycles, counted by an internal counter.
  - On the last ACCESS cycle, `mem_rdata` is registered into the winner's rdata register.
- **ACCESS, write**
  - `mem_we` = 1 on the first ACCESS cycle only.
  - `mem_low_o_en` stays 1.
  - `mem_wdata` is driven from the latched write data.
  - ACCESS still lasts WAIT_CYCLES cycles.
  - `d_rdata` is unchanged.
- **DONE**
  - Winner's ack = 1 for one cycle.
  - `mem_low_o_en` = 1 and `mem_we` = 0.
  - Always go to IDLE. This gives one bubble cycle between back-to-back accesses, and the acked requester must drop its request in that cycle.

Rules and boundary conditions:
- A fetch request with `d_we` asserted on the data port has no effect on the fetch. Write enable comes only from the data port.
- Address and data are latched in IDLE. Changes on request inputs after the grant are ignored until DONE.
- If a requester drops its request mid-access, the access still completes and is acked.
- Reset in any state:
  - FSM goes to IDLE and the counter clears.
  - Outputs take reset values: `mem_low_o_en` = 1, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `f_ack`/`d_ack` = 0, `f_rdata`/`d_rdata` = 0x00, `busy` = 0, `grant_id` = 0.
  - An aborted store must not assert `mem_we` after reset.
- Address wrap: addresses are 4-bit and all 16 values are valid; there is no wrap logic.

## Timing
- Request sampled high in IDLE at cycle N:
  - SETUP at N+1.
  - ACCESS from N+2 to N+1+WAIT_CYCLES.
  - Ack at N+2+WAIT_CYCLES.
- With WAIT_CYCLES = 1, ack arrives 3 cycles after sampling, for 4 cycles per access including the bubble.
- All outputs are registered. There is no combinational path from request inputs to `mem_*` outputs or acks.
- `mem_addr` is stable from SETUP through DONE.
- `mem_low_o_en` falls at least one cycle after `mem_addr` settles.
- `mem_rdata` is captured at the rising edge that ends the last ACCESS cycle.

## Configuration
The macro is `MEM_ACCESS_RR_EN`.
- **Undefined:** fixed priority, data over fetch. Fetch can starve under continuous data requests.
- **Defined:** round-robin on conflict.
  - A 1-bit last-grant register is updated on every grant and reset to 0 (fetch).
  - On a simultaneous request, the requester not granted last wins.
  - The first conflict after reset therefore goes to data.
  - A lone request is always granted immediately.

## Test plan
- **Reset defaults:** hold `rst` 2 cycles with both requests high, then release with requests low. Expect all outputs at reset values and `busy` = 0.
- **Single fetch:** `f_addr` = 0x1, `mem_rdata` model returns 0x49, WAIT_CYCLES = 1. Expect `mem_low_o_en` low in exactly one cycle, `f_ack` 3 cycles after the request, `f_rdata` = 0x49, `grant_id` = 0.
- **Store then load:** store `d_addr` = 0xA with `d_wdata` = 0x45, then load 0xA. Expect `mem_we` high for one cycle with `mem_addr` = 0xA and `mem_wdata` = 0x45, the load returns `d_rdata` = 0x45, and `f_rdata` is unchanged.
- **Simultaneous requests:** raise both requests in the same cycle, three times. Without the macro, expect data, data, data, with fetch served only once data drops. With `MEM_ACCESS_RR_EN`, expect data, fetch, data.
- **Reset mid-store:** assert `rst` during SETUP of a store to 0x9. Expect no `mem_we` pulse, no `d_ack`, and the FSM in IDLE the next cycle.
- **Wait states:** with WAIT_CYCLES = 3, load 0x8 returning 0x06. Expect `mem_low_o_en` low 3 cycles, `d_ack` 5 cycles after the request, and `d_rdata` = 0x06.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences the single 16x8 memory port between instruction fetch and data access.
// Define MEM_ACCESS_RR_EN for round-robin arbitration on conflict; default is fixed data-over-fetch priority.
//
// state  | meaning
// IDLE   | no access in flight; arbitrate and latch the winner on a request
// SETUP  | address driven, output enable still high
// ACCESS | WAIT_CYCLES cycles of output enable (read) or strobe-then-hold (write)
// DONE   | one-cycle ack to the winner; bubble before the next grant
module mem_access_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       f_req,
  input  logic [3:0] f_addr,
  output logic       f_ack,
  output logic [7:0] f_rdata,
  input  logic       d_req,
  input  logic       d_we,
  input  logic [3:0] d_addr,
  input  logic [7:0] d_wdata,
  output logic       d_ack,
  output logic [7:0] d_rdata,
  output logic [3:0] mem_addr,
  output logic       mem_low_o_en,
  output logic       mem_we,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic       busy,
  output logic       grant_id
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_nxt;
  logic       r_we;
  logic       r_gnt;
  logic [3:0] r_addr;
  logic [7:0] r_wdata;
  logic       r_oe_n;
  logic       r_mem_we;
  logic       r_busy;
  logic       r_f_ack;
  logic       r_d_ack;
  logic [7:0] r_f_rdata;
  logic [7:0] r_d_rdata;
  logic       w_win_data;
  logic       w_grant;
  logic       w_last_access;

`ifdef MEM_ACCESS_RR_EN
  logic r_last;
  // on conflict, whoever was not granted last time wins
  assign w_win_data = d_req & (~f_req | ~r_last);
`else
  assign w_win_data = d_req;
`endif

  assign w_grant       = (r_state == S_IDLE) && (f_req || d_req);
  assign w_last_access = (r_state == S_ACCESS) && (r_cnt == 3'd0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE:   if (f_req || d_req) w_state_nxt = S_SETUP;
      S_SETUP: begin
        w_state_nxt = S_ACCESS;
        w_cnt_nxt   = 3'(WAIT_CYCLES - 1);
      end
      S_ACCESS: begin
        if (r_cnt == 3'd0) w_state_nxt = S_DONE;
        else               w_cnt_nxt   = r_cnt - 3'd1;
      end
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // outputs are registered from the next state so they line up with the state they belong to
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 3'd0;
      r_we      <= 1'b0;
      r_gnt     <= 1'b0;
      r_addr    <= 4'h0;
      r_wdata   <= 8'h00;
      r_oe_n    <= 1'b1;
      r_mem_we  <= 1'b0;
      r_busy    <= 1'b0;
      r_f_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_f_rdata <= 8'h00;
      r_d_rdata <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_grant) begin
        r_gnt  <= w_win_data;
        r_we   <= w_win_data & d_we;
        r_addr <= w_win_data ? d_addr : f_addr;
        if (w_win_data && d_we) r_wdata <= d_wdata;
      end
      r_oe_n   <= !((w_state_nxt == S_ACCESS) && !r_we);
      r_mem_we <= (r_state == S_SETUP) && r_we;
      r_busy   <= (w_state_nxt != S_IDLE);
      r_f_ack  <= w_last_access && !r_gnt;
      r_d_ack  <= w_last_access && r_gnt;
      if (w_last_access && !r_we) begin
        if (r_gnt) r_d_rdata <= mem_rdata;
        else       r_f_rdata <= mem_rdata;
      end
    end
  end

`ifdef MEM_ACCESS_RR_EN
  always_ff @(posedge clk) begin
    if (rst)          r_last <= 1'b0;
    else if (w_grant) r_last <= w_win_data;
  end
`endif

  assign f_ack        = r_f_ack;
  assign f_rdata      = r_f_rdata;
  assign d_ack        = r_d_ack;
  assign d_rdata      = r_d_rdata;
  assign mem_addr     = r_addr;
  assign mem_low_o_en = r_oe_n;
  assign mem_we       = r_mem_we;
  assign mem_wdata    = r_wdata;
  assign busy         = r_busy;
  assign grant_id     = r_gnt;

endmodule
